// File: rtl/disp_ctrl.sv
// Four-digit display controller: converts a 14-bit binary value to BCD by
// sequential double-dabble, holds the result for the seven-segment decoders,
// and drives per-digit blanking for leading zeros and whole-display blinking.
module disp_ctrl #(
   parameter int BLINK_DIV = 25000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [13:0] value,
   input  logic        blank_en,
   input  logic        blink_en,
   output logic        busy,
   output logic        ovf,
   output logic [15:0] digits,
   output logic [3:0]  off
);

   localparam int CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
   localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_DIV - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

   state_t        state_q, state_d;
   logic [13:0]   bin_q, bin_d;
   logic [15:0]   bcd_q, bcd_d;
   logic [3:0]    iter_q, iter_d;
   logic          ovf_q, ovf_d;
   logic [15:0]   digits_q, digits_d;
   logic [CW-1:0] blink_q, blink_d;
   logic          phase_q, phase_d;
   logic [15:0]   adj;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state: accept a load in IDLE, run 14 iterations, then publish
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (load) state_d = SHIFT;
         SHIFT:   if (iter_q == 4'd13) state_d = UPDATE;
         UPDATE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath next-state: capture/saturate, double-dabble step, result copy
   always_comb begin
      bin_d    = bin_q;
      bcd_d    = bcd_q;
      iter_d   = iter_q;
      ovf_d    = ovf_q;
      digits_d = digits_q;
      adj      = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                   : bcd_q[4*i +: 4];
      end
      case (state_q)
         IDLE: begin
            if (load) begin
               ovf_d  = (value > 14'd9999);
               bin_d  = (value > 14'd9999) ? 14'd9999 : value;
               bcd_d  = '0;
               iter_d = '0;
            end
         end
         SHIFT: begin
            // top bit of the 30-bit shift is always zero for inputs <= 9999
            {bcd_d, bin_d} = {adj[14:0], bin_q, 1'b0};
            iter_d         = iter_q + 4'd1;
         end
         UPDATE:  digits_d = bcd_q;
         default: ;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bin_q    <= '0;
         bcd_q    <= '0;
         iter_q   <= '0;
         ovf_q    <= 1'b0;
         digits_q <= '0;
      end else begin
         bin_q    <= bin_d;
         bcd_q    <= bcd_d;
         iter_q   <= iter_d;
         ovf_q    <= ovf_d;
         digits_q <= digits_d;
      end
   end

   // Free-running blink divider; phase flips on each wrap
   always_comb begin
      blink_d = blink_q + 1'b1;
      phase_d = phase_q;
      if (blink_q == BLINK_LAST) begin
         blink_d = '0;
         phase_d = ~phase_q;
      end
   end

   // Blink divider registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blink_q <= '0;
         phase_q <= 1'b0;
      end else begin
         blink_q <= blink_d;
         phase_q <= phase_d;
      end
   end

   // Outputs: busy from state, blanking from registered digits and phase
   always_comb begin
      busy   = (state_q != IDLE);
      ovf    = ovf_q;
      digits = digits_q;
      off    = '0;
      if (blank_en) begin
         off[3] = (digits_q[15:12] == 4'd0);
         off[2] = off[3] && (digits_q[11:8] == 4'd0);
         off[1] = off[2] && (digits_q[7:4] == 4'd0);
      end
      if (blink_en && phase_q) off = '1;
   end

endmodule

// File: tb/tb_disp_ctrl.sv
// Self-checking bench for disp_ctrl: vector table, corner-case sequences
// and randomized loads against a decimal-arithmetic reference model.
module tb_disp_ctrl;

   localparam int BD = 4;

   logic        clk;
   logic        rst;
   logic        load;
   logic [13:0] value;
   logic        blank_en;
   logic        blink_en;
   logic        busy;
   logic        ovf;
   logic [15:0] digits;
   logic [3:0]  off;

   int tests = 0;
   int fails = 0;
   int n_edges;
   logic [15:0] cur_digits;

   disp_ctrl #(.BLINK_DIV(BD)) dut (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .value    (value),
      .blank_en (blank_en),
      .blink_en (blink_en),
      .busy     (busy),
      .ovf      (ovf),
      .digits   (digits),
      .off      (off)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Clock edges seen since reset released; blink phase derives from this
   always @(posedge clk or posedge rst) begin
      if (rst) n_edges <= 0;
      else     n_edges <= n_edges + 1;
   end

   typedef struct {
      logic [13:0] value;
      logic        blank;
      logic [15:0] exp_digits;
      logic [3:0]  exp_off;
      logic        exp_ovf;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] model_digits(input int v);
      int d;
      d = (v > 9999) ? 9999 : v;
      return {4'(d / 1000), 4'((d / 100) % 10), 4'((d / 10) % 10), 4'(d % 10)};
   endfunction

   function automatic logic [3:0] model_off(input logic [15:0] d, input logic blank,
                                            input logic blink, input int edges);
      int num;
      int lz;
      logic [3:0] r;
      if (blink && ((edges / BD) % 2 == 1)) return 4'b1111;
      r = 4'b0000;
      if (!blank) return r;
      num = 1000 * d[15:12] + 100 * d[11:8] + 10 * d[7:4] + d[3:0];
      lz = (num < 10) ? 3 : (num < 100) ? 2 : (num < 1000) ? 1 : 0;
      for (int k = 0; k < lz; k++) r[3 - k] = 1'b1;
      return r;
   endfunction

   // Waits for the running conversion to finish, checking latency and hold
   task automatic wait_done(input string name, input int v, input int inj_cyc,
                            input logic [13:0] inj_v);
      int cyc;
      logic hold_ok;
      logic [15:0] exp_d;
      cyc = 0;
      hold_ok = 1'b1;
      while (busy && cyc < 40) begin
         if (inj_cyc != 0 && cyc + 1 == inj_cyc) begin
            @(negedge clk);
            value = inj_v;
            load  = 1'b1;
         end
         @(posedge clk);
         #1;
         load = 1'b0;
         cyc++;
         if (busy && digits !== cur_digits) hold_ok = 1'b0;
      end
      check({name, " latency"}, cyc, 15);
      check({name, " hold"}, {31'd0, hold_ok}, 1);
      exp_d = model_digits(v);
      check({name, " digits"}, digits, exp_d);
      check({name, " ovf"}, ovf, (v > 9999) ? 1 : 0);
      cur_digits = exp_d;
   endtask

   task automatic run_conv(input string name, input logic [13:0] v, input int inj_cyc,
                           input logic [13:0] inj_v);
      @(negedge clk);
      value = v;
      load  = 1'b1;
      @(posedge clk);
      #1;
      load = 1'b0;
      check({name, " busy"}, busy, 1);
      wait_done(name, int'(v), inj_cyc, inj_v);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{14'd1234,  1'b0, 16'h1234, 4'b0000, 1'b0};
      vecs[1] = '{14'd42,    1'b1, 16'h0042, 4'b1100, 1'b0};
      vecs[2] = '{14'd0,     1'b1, 16'h0000, 4'b1110, 1'b0};
      vecs[3] = '{14'd12000, 1'b0, 16'h9999, 4'b0000, 1'b1};
      vecs[4] = '{14'd5,     1'b0, 16'h0005, 4'b0000, 1'b0};
      vecs[5] = '{14'd5,     1'b1, 16'h0005, 4'b1110, 1'b0};
      vecs[6] = '{14'd16383, 1'b1, 16'h9999, 4'b0000, 1'b1};
      vecs[7] = '{14'd100,   1'b1, 16'h0100, 4'b1000, 1'b0};
      vecs[8] = '{14'd1000,  1'b1, 16'h1000, 4'b0000, 1'b0};
      vecs[9] = '{14'd10000, 1'b1, 16'h9999, 4'b0000, 1'b1};

      rst = 1'b1; load = 1'b0; value = '0; blank_en = 1'b1; blink_en = 1'b0;
      cur_digits = 16'h0000;
      #12;
      check("reset busy", busy, 0);
      check("reset ovf", ovf, 0);
      check("reset digits", digits, 16'h0000);
      check("reset off blank", off, 4'b1110);
      blank_en = 1'b0;
      #1;
      check("reset off noblank", off, 4'b0000);
      @(negedge clk);
      rst = 1'b0;

      // Vector table
      for (int i = 0; i < 10; i++) begin
         blank_en = vecs[i].blank;
         run_conv($sformatf("vec%0d", i), vecs[i].value, 0, '0);
         check($sformatf("vec%0d tdigits", i), digits, vecs[i].exp_digits);
         check($sformatf("vec%0d tovf", i), ovf, vecs[i].exp_ovf);
         check($sformatf("vec%0d toff", i), off, vecs[i].exp_off);
      end

      // Load during busy is ignored
      blank_en = 1'b0;
      run_conv("ignore", 14'd1111, 5, 14'd2222);
      check("ignore final", digits, 16'h1111);
      @(posedge clk);
      #1;
      check("ignore idle", busy, 0);

      // Reset mid-conversion, then load on first edge after release
      @(negedge clk);
      value = 14'd9999;
      load  = 1'b1;
      @(posedge clk);
      #1;
      load = 1'b0;
      repeat (7) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("abort busy", busy, 0);
      check("abort digits", digits, 16'h0000);
      check("abort ovf", ovf, 0);
      cur_digits = 16'h0000;
      @(negedge clk);
      rst   = 1'b0;
      value = 14'd7;
      load  = 1'b1;
      @(posedge clk);
      #1;
      load = 1'b0;
      check("post-reset busy", busy, 1);
      wait_done("post-reset", 7, 0, '0);

      // Blinking over a nonzero display
      run_conv("blinkld", 14'd1234, 0, '0);
      blink_en = 1'b1;
      for (int c = 0; c < 16; c++) begin
         @(posedge clk);
         #1;
         check($sformatf("blink%0d", c), off, model_off(16'h1234, 1'b0, 1'b1, n_edges));
      end
      blink_en = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk);
         #1;
         check($sformatf("noblink%0d", c), off, 4'b0000);
      end

      // Randomized loads against the model
      for (int r = 0; r < 30; r++) begin
         logic [13:0] rv;
         rv = (r % 4 == 0) ? 14'($urandom_range(9990, 16383)) : 14'($urandom_range(0, 9999));
         if (r % 5 == 0) rv = 14'($urandom_range(0, 120));
         blank_en = 1'($urandom_range(0, 1));
         blink_en = 1'($urandom_range(0, 1));
         run_conv($sformatf("rnd%0d", r), rv, 0, '0);
         check($sformatf("rnd%0d off", r), off,
               model_off(cur_digits, blank_en, blink_en, n_edges));
         repeat (int'($urandom_range(0, 3))) @(posedge clk);
         #1;
         check($sformatf("rnd%0d off2", r), off,
               model_off(cur_digits, blank_en, blink_en, n_edges));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
